// File: rtl/link_pkg.sv
// Shared definitions for the UART-to-link packet sequencer.
//   tx_state_e   : 3-bit tx FSM encoding
//   BUSY_TIMEOUT : cycles to wait for the sender to raise busy before moving on
package link_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    CRC     = 3'd4,
    CRC_HI  = 3'd5,
    CRC_LO  = 3'd6,
    DONE    = 3'd7
  } tx_state_e;

  localparam int BUSY_TIMEOUT = 4;
  localparam int TO_W         = $clog2(BUSY_TIMEOUT);

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with registered read data.
//   push/din   : write when not full (or when a pop frees the slot this cycle)
//   pop/dout   : dout loads the head entry on a pop of a non-empty FIFO
//   full/empty : from read/write pointers carrying one extra wrap bit
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/link_packet_ctrl.sv
// Start-triggered packet sequencer: collects PKT_LEN bytes from the UART into
// a FIFO, forwards them one at a time to the inter-FPGA sender while feeding
// the CRC module, then sends the CRC8 as a trailer byte.
//   clk, reset                  : clock, async active-high reset
//   i_start                     : start level, rising edge begins a packet
//   i_8_rx_data/i_rx_ready      : UART byte + ready level; o_rx_clear acks it
//   o_8_crc_data/o_crc_en/_rst  : CRC update byte/pulse, CRC clear pulse
//   i_8_crc                     : running CRC8
//   o_8_tx_data/o_tx_send       : byte + send pulse to the link; i_tx_busy back
//   o_busy/o_done/o_8_count     : packet status, done pulse, bytes sent
module link_packet_ctrl
  import link_pkg::*;
#(
  parameter int PKT_LEN    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_8_rx_data,
  input  logic       i_rx_ready,
  output logic       o_rx_clear,
  output logic [7:0] o_8_crc_data,
  output logic       o_crc_en,
  output logic       o_crc_rst,
  input  logic [7:0] i_8_crc,
  output logic [7:0] o_8_tx_data,
  output logic       o_tx_send,
  input  logic       i_tx_busy,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_8_count
);

  localparam logic [7:0]      PKT_LEN_B = 8'(PKT_LEN);
  localparam logic [7:0]      TX_LAST_B = 8'(PKT_LEN - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(BUSY_TIMEOUT - 1);

  tx_state_e       state;
  logic            start_q;
  logic            start_go;
  logic [7:0]      rx_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      crc_q;
  logic            sel_crc;
  logic            accept, pop;
  logic            fifo_full, fifo_empty;
  logic [7:0]      fifo_dout;

  assign start_go = (state == IDLE) && !o_busy && i_start && !start_q;

  // The previous-cycle clear blocks a second accept while the UART's ready
  // level is still falling from our own ack.
  assign accept = o_busy && (rx_cnt < PKT_LEN_B) && i_rx_ready &&
                  !fifo_full && !o_rx_clear;
  assign pop    = (state == SEND) && !fifo_empty && !i_tx_busy;

  // Payload comes straight from the FIFO's registered head; the trailer from
  // the latched CRC. Both sources only change at a send, so the byte holds
  // steady while the sender is busy.
  assign o_8_tx_data = sel_crc ? crc_q : fifo_dout;

  byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (accept),
    .pop   (pop),
    .din   (i_8_rx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Rx side: ack, CRC feed and push all happen together on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt       <= '0;
      o_rx_clear   <= 1'b0;
      o_crc_en     <= 1'b0;
      o_8_crc_data <= '0;
    end else begin
      o_rx_clear <= 1'b0;
      o_crc_en   <= 1'b0;
      if (start_go) begin
        rx_cnt <= '0;
      end else if (accept) begin
        o_rx_clear   <= 1'b1;
        o_crc_en     <= 1'b1;
        o_8_crc_data <= i_8_rx_data;
        rx_cnt       <= rx_cnt + 8'd1;
      end
    end
  end

  // Tx FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      to_cnt    <= '0;
      o_8_count <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_crc_rst <= 1'b0;
      o_tx_send <= 1'b0;
      crc_q     <= '0;
      sel_crc   <= 1'b0;
    end else begin
      start_q   <= i_start;
      o_crc_rst <= 1'b0;
      o_tx_send <= 1'b0;
      o_done    <= 1'b0;
      case (state)
        IDLE: if (start_go) begin
          o_crc_rst <= 1'b1;
          o_8_count <= '0;
          o_busy    <= 1'b1;
          sel_crc   <= 1'b0;
          state     <= SEND;
        end
        SEND: if (pop) begin
          o_tx_send <= 1'b1;
          to_cnt    <= '0;
          state     <= WAIT_HI;
        end
        // A sender that never raises busy is treated as having taken the byte.
        WAIT_HI, CRC_HI: begin
          if (i_tx_busy || to_cnt == TO_LAST)
            state <= (state == WAIT_HI) ? WAIT_LO : CRC_LO;
          else
            to_cnt <= to_cnt + 1'b1;
        end
        WAIT_LO: if (!i_tx_busy) begin
          if (o_8_count != PKT_LEN_B) o_8_count <= o_8_count + 8'd1;
          state <= (o_8_count == TX_LAST_B) ? CRC : SEND;
        end
        CRC: begin
          crc_q     <= i_8_crc;
          sel_crc   <= 1'b1;
          o_tx_send <= 1'b1;
          to_cnt    <= '0;
          state     <= CRC_HI;
        end
        CRC_LO: if (!i_tx_busy) state <= DONE;
        DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/link_packet_ctrl.md
# link_packet_ctrl

Packet sequencer between the PC-side `uart_receiver` and the `interfpga_send` link. It collects a fixed-length packet of bytes from the UART and buffers them in a small FIFO. It forwards the bytes one at a time over the inter-FPGA link, feeds each byte to the `crc` module, and after the last payload byte transmits the CRC8 as a trailer byte. It replaces the free-running UART-to-link wiring in the PC-to-FPGA top level with a start-triggered, framed transfer.

## Interface
Parameters:
- `PKT_LEN`, 16: payload bytes per packet, range 1..255.
- `FIFO_DEPTH`, 4: byte buffer depth, power of two, at least 2.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `i_start`  in  1  debounced start level. A rising edge starts a packet.
- `i_8_rx_data`  in  8  byte from `uart_receiver`.
- `i_rx_ready`  in  1  level, held high until cleared.
- `o_rx_clear`  out  1  one-cycle pulse that clears `i_rx_ready`.
- `o_8_crc_data`  out  8  byte presented to `crc`.
- `o_crc_en`  out  1  one-cycle CRC update pulse.
- `o_crc_rst`  out  1  one-cycle CRC clear pulse.
- `i_8_crc`  in  8  current CRC8 value.
- `o_8_tx_data`  out  8  byte to `interfpga_send`.
- `o_tx_send`  out  1  one-cycle send pulse.
- `i_tx_busy`  in  1  sender busy level.
- `o_busy`  out  1  high from start until done.
- `o_done`  out  1  one-cycle pulse when the trailer has completed.
- `o_8_count`  out  8  payload bytes sent in the current packet.

## Operation
- Reset values: all outputs 0. FIFO empty, counters 0, tx FSM in IDLE.
- Start:
  - In IDLE, a rising edge of `i_start` pulses `o_crc_rst`, clears the counters and asserts `o_busy`.
  - `i_start` edges while `o_busy` is high are ignored.
- Rx side:
  - Accepts a byte only when all of these hold: `o_busy` is high, `rx_cnt < PKT_LEN`, `i_rx_ready` is high, the FIFO is not full, and `o_rx_clear` was not asserted in the previous cycle.
  - On accept, in the same registered cycle: push `i_8_rx_data`, pulse `o_rx_clear` and `o_crc_en` with `o_8_crc_data` equal to the byte, and increment `rx_cnt`.
  - Bytes that arrive while idle or after `PKT_LEN` are left pending; `i_rx_ready` is not cleared.
- Tx FSM states:
  - IDLE → (start) → SEND.
  - SEND: if the FIFO is non-empty and `i_tx_busy` is low, pop the FIFO into `o_8_tx_data`, pulse `o_tx_send` and go to WAIT_HI.
  - WAIT_HI: `i_tx_busy` high → WAIT_LO. If busy has not risen after 4 cycles, go to WAIT_LO anyway; this is the lost-handshake guard.
  - WAIT_LO: `i_tx_busy` low → increment `tx_cnt`. If `tx_cnt == PKT_LEN` go to CRC, else go to SEND.
  - CRC: latch `i_8_crc` into `o_8_tx_data`, pulse `o_tx_send` and go to CRC_HI.
  - CRC_HI and CRC_LO behave the same as WAIT_HI and WAIT_LO, then go to DONE.
  - DONE: pulse `o_done`, deassert `o_busy`, go to IDLE.
- `o_8_count` equals `tx_cnt`. It wraps never: the count saturates at `PKT_LEN`.
- FIFO is full/empty by pointer comparison with one extra wrap bit.
- Simultaneous push and pop in the same cycle is legal, including when the FIFO is full (the pop frees the slot) or empty (no pop occurs).
- Asynchronous `reset` mid-packet flushes the FIFO, returns the FSM to IDLE and drops all pulses. The partial packet is discarded.

## Timing
- `i_rx_ready` rises at cycle t → `o_rx_clear`, `o_crc_en` and the FIFO write occur at t+1.
- Empty FIFO with push at t → `o_tx_send` at t+2 at the earliest; SEND sees the entry at t+1.
- `o_8_tx_data` is stable from the `o_tx_send` cycle until busy falls.
- The trailer CRC is sampled at least 2 cycles after the last `o_crc_en`, since the last payload byte is received before it is sent.
- Packet latency: fixed 3 cycles of overhead per byte plus the sender busy time.

## Structure
- The shared package `link_pkg` holds:
  - the FSM state encoding, 3 bits: IDLE, SEND, WAIT_HI, WAIT_LO, CRC, CRC_HI, CRC_LO, DONE;
  - the localparam `BUSY_TIMEOUT = 4`.
- Sub-module `byte_fifo` (parameters `WIDTH`, `DEPTH`) with ports `push`, `pop`, `din`, `dout`, `full`, `empty`. Output is registered on pop.
- The rising-edge detector for `i_start` is inline.

## Test plan
- `PKT_LEN`=4, start, then UART bytes 0x01, 0x02, 0x03, 0x04 → link sends 01 02 03 04 then the CRC8 of those bytes; `o_done` pulses once and `o_8_count`=4.
- 8 bytes arrive back-to-back while the sender busy lasts 100 cycles → FIFO fills to 4 and `o_rx_clear` stalls. All 8 bytes are sent in order with none lost (`PKT_LEN`=8).
- UART byte 0x55 arrives before start → it is not cleared while idle; after start it is accepted as payload byte 1.
- Sender never raises busy → each byte advances after the 4-cycle timeout and the packet still completes.
- `reset` asserted after 2 of 4 bytes → all outputs 0 immediately. A new start sends a fresh packet and the CRC is restarted (`o_crc_rst` pulses).
- `i_start` toggled during a packet → ignored; exactly one `o_done` is produced.
